// File: rtl/gsensor_spi_responder.sv
// ---------------------------------------------------------------------------
// gsensor_spi_responder
// 3-wire SPI responder that emulates the board G-sensor. It oversamples the
// SPI pins on clk_clk and serves a small register file that holds live X/Y/Z
// samples. The interrupt is raised when new data arrives.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on spi_sclk/spi_cs_n/spi_sdat_i (2..3)
//   DEVID        value returned at address 0x00
//
// Optional feature macro: GSENSOR_OFFSET_EN
//   When defined, adds OFSX/OFSY/OFSZ (0x1E/0x1F/0x20). Each offset is
//   sign-extended and added to the matching captured sample.
//
// Ports:
//   clk_clk         system clock (>= 8x SCLK)
//   reset_reset_n   asynchronous active-low reset
//   spi_sclk        SPI clock from master, CPOL=1 CPHA=1
//   spi_cs_n        chip select, active low
//   spi_sdat_i      data pin, input side
//   spi_sdat_o      data pin drive value
//   spi_sdat_oe     tristate enable for spi_sdat_o
//   g_sensor_int    interrupt, active high
//   sample_valid    one-cycle pulse: new sample on sample_x/y/z
//   sample_x/y/z    16-bit two's complement samples
//   busy            high while synchronised CS_N is low
// ---------------------------------------------------------------------------
module gsensor_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hE5
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_i,
  output logic        spi_sdat_o,
  output logic        spi_sdat_oe,
  output logic        g_sensor_int,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic        busy
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Pin synchronisers and edge detection
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic w_sclk_s, w_cs_s, w_sdat_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdat_s    = r_sdat_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_cs_rise   = w_cs_s & ~r_cs_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_sdat_sync <= '0;
      r_sclk_prev <= 1'b1;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], spi_sdat_i};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Transaction datapath state
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [BYTE_W-1:0]   r_rx_sh;
  logic [BYTE_W-1:0]   r_tx_sh;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_mb;
  logic                r_rd_flag;
  logic                r_sdat_o;
  logic                r_oe;

  // Register file
  logic [BYTE_W-1:0]   r_bw_rate;
  logic [BYTE_W-1:0]   r_power_ctl;
  logic [BYTE_W-1:0]   r_int_enable;
  logic [BYTE_W-1:0]   r_data_format;
  logic                r_data_ready;
  logic [SAMPLE_W-1:0] r_data_x, r_data_y, r_data_z;
  logic [SAMPLE_W-1:0] r_pend_x, r_pend_y, r_pend_z;
  logic                r_pend_vld;
  logic                r_int;
  logic                r_busy;
`ifdef GSENSOR_OFFSET_EN
  logic [BYTE_W-1:0]   r_ofs_x, r_ofs_y, r_ofs_z;
`endif

  logic                w_active_rise;
  logic                w_cmd_done;
  logic                w_byte_done;
  logic                w_wr_en;
  logic                w_addr_is_data;
  logic                w_cap;
  logic [BYTE_W-1:0]   w_rx_nxt;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [BYTE_W-1:0]   w_rd_data;
  logic [SAMPLE_W-1:0] w_cap_x, w_cap_y, w_cap_z;

  assign w_rx_nxt       = {r_rx_sh[BYTE_W-2:0], w_sdat_s};
  assign w_active_rise  = w_sclk_rise & ~w_cs_rise &
                          ((r_state == S_CMD) || (r_state == S_READ) || (r_state == S_WRITE));
  assign w_wr_en        = w_byte_done & (r_state == S_WRITE);
  assign w_addr_is_data = (r_addr >= 6'h32) && (r_addr <= 6'h37);
  assign w_cap          = sample_valid & r_power_ctl[3];

  // Command phase reads the freshly received address; bursts read the next one
  assign w_rd_addr = (r_state == S_CMD) ? w_rx_nxt[ADDR_W-1:0]
                                        : ADDR_W'(r_addr + ADDR_W'(1));

`ifdef GSENSOR_OFFSET_EN
  assign w_cap_x = SAMPLE_W'(sample_x + {{8{r_ofs_x[7]}}, r_ofs_x});
  assign w_cap_y = SAMPLE_W'(sample_y + {{8{r_ofs_y[7]}}, r_ofs_y});
  assign w_cap_z = SAMPLE_W'(sample_z + {{8{r_ofs_z[7]}}, r_ofs_z});
`else
  assign w_cap_x = sample_x;
  assign w_cap_y = sample_y;
  assign w_cap_z = sample_z;
`endif

  // Register read mux
  always_comb begin
    w_rd_data = '0;
    case (w_rd_addr)
      6'h00:   w_rd_data = DEVID;
      6'h2C:   w_rd_data = r_bw_rate;
      6'h2D:   w_rd_data = r_power_ctl;
      6'h2E:   w_rd_data = r_int_enable;
      6'h30:   w_rd_data = {r_data_ready, 7'b0};
      6'h31:   w_rd_data = r_data_format;
      6'h32:   w_rd_data = r_data_x[7:0];
      6'h33:   w_rd_data = r_data_x[15:8];
      6'h34:   w_rd_data = r_data_y[7:0];
      6'h35:   w_rd_data = r_data_y[15:8];
      6'h36:   w_rd_data = r_data_z[7:0];
      6'h37:   w_rd_data = r_data_z[15:8];
`ifdef GSENSOR_OFFSET_EN
      6'h1E:   w_rd_data = r_ofs_x;
      6'h1F:   w_rd_data = r_ofs_y;
      6'h20:   w_rd_data = r_ofs_z;
`endif
      default: w_rd_data = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // FSM next state and byte-boundary strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_done  = 1'b0;
    w_byte_done = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_sclk_rise && (r_bit_cnt == CNT_W'(7))) begin
            w_cmd_done  = 1'b1;
            w_state_nxt = w_rx_nxt[7] ? S_READ : S_WRITE;
          end
        end
        S_READ, S_WRITE: begin
          if (w_sclk_rise && (r_bit_cnt == CNT_W'(7))) begin
            w_byte_done = 1'b1;
            if (!r_mb) w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Shift registers, address tracking and pin drive
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_bit_cnt <= '0;
      r_rx_sh   <= '0;
      r_tx_sh   <= '0;
      r_addr    <= '0;
      r_mb      <= 1'b0;
      r_rd_flag <= 1'b0;
      r_sdat_o  <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      if (r_state == S_IDLE)   r_bit_cnt <= '0;
      else if (w_active_rise)  r_bit_cnt <= CNT_W'(r_bit_cnt + CNT_W'(1));

      if (w_active_rise && (r_state != S_READ)) r_rx_sh <= w_rx_nxt;

      if (w_cmd_done) begin
        r_mb   <= w_rx_nxt[6];
        r_addr <= w_rx_nxt[ADDR_W-1:0];
        if (w_rx_nxt[7]) r_tx_sh <= w_rd_data;
      end else if (w_byte_done && r_mb) begin
        r_addr <= w_rd_addr;
        if (r_state == S_READ) r_tx_sh <= w_rd_data;
      end else if (w_sclk_fall && !w_cs_rise && (r_state == S_READ)) begin
        r_tx_sh <= {r_tx_sh[BYTE_W-2:0], 1'b0};
      end

      if (w_cs_rise || w_cs_fall)                               r_rd_flag <= 1'b0;
      else if (w_byte_done && (r_state == S_READ) && w_addr_is_data) r_rd_flag <= 1'b1;

      if (w_cs_rise || (r_state == S_IDLE) || (r_state == S_DONE)) begin
        r_oe <= 1'b0;
      end else if (w_sclk_fall && (r_state == S_READ)) begin
        r_oe     <= 1'b1;
        r_sdat_o <= r_tx_sh[BYTE_W-1];
      end
    end
  end

  // Register writes, sample capture with CS-coherent pending buffer, interrupt
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_bw_rate     <= 8'h0A;
      r_power_ctl   <= '0;
      r_int_enable  <= '0;
      r_data_format <= '0;
      r_data_ready  <= 1'b0;
      r_data_x      <= '0;
      r_data_y      <= '0;
      r_data_z      <= '0;
      r_pend_x      <= '0;
      r_pend_y      <= '0;
      r_pend_z      <= '0;
      r_pend_vld    <= 1'b0;
      r_int         <= 1'b0;
      r_busy        <= 1'b0;
`ifdef GSENSOR_OFFSET_EN
      r_ofs_x       <= '0;
      r_ofs_y       <= '0;
      r_ofs_z       <= '0;
`endif
    end else begin
      if (w_wr_en) begin
        case (r_addr)
          6'h2C:   r_bw_rate     <= w_rx_nxt;
          6'h2D:   r_power_ctl   <= w_rx_nxt;
          6'h2E:   r_int_enable  <= w_rx_nxt;
          6'h31:   r_data_format <= w_rx_nxt;
`ifdef GSENSOR_OFFSET_EN
          6'h1E:   r_ofs_x       <= w_rx_nxt;
          6'h1F:   r_ofs_y       <= w_rx_nxt;
          6'h20:   r_ofs_z       <= w_rx_nxt;
`endif
          default: ;
        endcase
      end

      if (w_cs_s) begin
        // A fresh pulse is newer than anything pending; any set beats the clear
        if (w_cap) begin
          r_data_x     <= w_cap_x;
          r_data_y     <= w_cap_y;
          r_data_z     <= w_cap_z;
          r_data_ready <= 1'b1;
        end else if (w_cs_rise && r_pend_vld) begin
          r_data_x     <= r_pend_x;
          r_data_y     <= r_pend_y;
          r_data_z     <= r_pend_z;
          r_data_ready <= 1'b1;
        end else if (w_cs_rise && r_rd_flag) begin
          r_data_ready <= 1'b0;
        end
        r_pend_vld <= 1'b0;
      end else if (w_cap) begin
        r_pend_x   <= w_cap_x;
        r_pend_y   <= w_cap_y;
        r_pend_z   <= w_cap_z;
        r_pend_vld <= 1'b1;
      end

      r_int  <= r_data_ready & r_int_enable[7];
      r_busy <= ~w_cs_s;
    end
  end

  assign spi_sdat_o   = r_sdat_o;
  assign spi_sdat_oe  = r_oe;
  assign g_sensor_int = r_int;
  assign busy         = r_busy;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_gsensor_spi_responder
// Drives the responder as an SPI master (CPOL=1, CPHA=1). A register-access
// vector table is applied in a loop. Multi-cycle corner cases are written out
// by hand: sample capture, coherent bursts, address wrap, aborted write and
// offsets. Expected read bytes are queued before each transaction and popped
// as the bytes arrive on spi_sdat_o.
// ---------------------------------------------------------------------------
module tb_gsensor_spi_responder;

  localparam int HALF = 60;

`ifdef GSENSOR_OFFSET_EN
  localparam logic [7:0] OFS_RB = 8'h7F;
`else
  localparam logic [7:0] OFS_RB = 8'h00;
`endif

  logic        clk_clk       = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        spi_sclk      = 1'b1;
  logic        spi_cs_n      = 1'b1;
  logic        spi_sdat_i    = 1'b0;
  logic        sample_valid  = 1'b0;
  logic [15:0] sample_x      = '0;
  logic [15:0] sample_y      = '0;
  logic [15:0] sample_z      = '0;
  logic        spi_sdat_o;
  logic        spi_sdat_oe;
  logic        g_sensor_int;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          oe_bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] nx = '0, ny = '0, nz = '0;

  typedef struct {
    bit         rd;
    logic [5:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  gsensor_spi_responder dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi_sclk      (spi_sclk),
    .spi_cs_n      (spi_cs_n),
    .spi_sdat_i    (spi_sdat_i),
    .spi_sdat_o    (spi_sdat_o),
    .spi_sdat_oe   (spi_sdat_oe),
    .g_sensor_int  (g_sensor_int),
    .sample_valid  (sample_valid),
    .sample_x      (sample_x),
    .sample_y      (sample_y),
    .sample_z      (sample_z),
    .busy          (busy)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk_clk);
    sample_x     = x;
    sample_y     = y;
    sample_z     = z;
    sample_valid = 1'b1;
    @(negedge clk_clk);
    sample_valid = 1'b0;
  endtask

  // Clocks nbits bits MSB first; records oe disagreements at each rising edge
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit exp_oe,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sclk   = 1'b0;
      spi_sdat_i = tx[i];
      #(HALF);
      spi_sclk = 1'b1;
      rx[i]    = spi_sdat_o;
      if (spi_sdat_oe !== exp_oe) oe_bad++;
      #(HALF);
    end
  endtask

  task automatic spi_end();
    #(HALF);
    spi_cs_n = 1'b1;
    #(2 * HALF);
  endtask

  task automatic read_burst(input string name, input logic [5:0] addr, input int n,
                            input bit mb, input int pulse_after);
    logic [7:0] rx;
    logic [7:0] exp;
    oe_bad   = 0;
    spi_cs_n = 1'b0;
    #(HALF);
    spi_bits({1'b1, mb, addr}, 8, 1'b0, rx);
    for (int b = 0; b < n; b++) begin
      spi_bits(8'h00, 8, 1'b1, rx);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s[%0d]: got 0x%02h with no expected byte queued", name, b, rx);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("%s[%0d]", name, b), 32'(rx), 32'(exp));
      end
      if (b == pulse_after) pulse_sample(nx, ny, nz);
    end
    check({name, "_oe_phase"}, 32'(oe_bad), 32'd0);
    spi_end();
    check({name, "_oe_release"}, 32'(spi_sdat_oe), 32'd0);
  endtask

  task automatic write_reg(input logic [5:0] addr, input logic [7:0] data);
    logic [7:0] rx;
    oe_bad   = 0;
    spi_cs_n = 1'b0;
    #(HALF);
    spi_bits({2'b00, addr}, 8, 1'b0, rx);
    spi_bits(data, 8, 1'b0, rx);
    spi_end();
    check($sformatf("wr%02h_oe", addr), 32'(oe_bad), 32'd0);
  endtask

  initial begin
    logic [7:0] rx;

    vecs.push_back('{1'b1, 6'h00, 8'hE5});
    vecs.push_back('{1'b1, 6'h2C, 8'h0A});
    vecs.push_back('{1'b1, 6'h2D, 8'h00});
    vecs.push_back('{1'b1, 6'h2E, 8'h00});
    vecs.push_back('{1'b1, 6'h30, 8'h00});
    vecs.push_back('{1'b1, 6'h31, 8'h00});
    vecs.push_back('{1'b1, 6'h32, 8'h00});
    vecs.push_back('{1'b1, 6'h10, 8'h00});
    vecs.push_back('{1'b0, 6'h2D, 8'h08});
    vecs.push_back('{1'b1, 6'h2D, 8'h08});
    vecs.push_back('{1'b0, 6'h30, 8'hFF});
    vecs.push_back('{1'b1, 6'h30, 8'h00});
    vecs.push_back('{1'b0, 6'h31, 8'h0B});
    vecs.push_back('{1'b1, 6'h31, 8'h0B});
    vecs.push_back('{1'b0, 6'h00, 8'h12});
    vecs.push_back('{1'b1, 6'h00, 8'hE5});
    vecs.push_back('{1'b0, 6'h1E, 8'h7F});
    vecs.push_back('{1'b1, 6'h1E, OFS_RB});
    vecs.push_back('{1'b0, 6'h1E, 8'h00});
    vecs.push_back('{1'b0, 6'h2E, 8'h80});
    vecs.push_back('{1'b1, 6'h2E, 8'h80});

    // Reset state
    #52;
    check("rst_sdat_o", 32'(spi_sdat_o), 32'd0);
    check("rst_oe", 32'(spi_sdat_oe), 32'd0);
    check("rst_int", 32'(g_sensor_int), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);

    // busy follows synchronised CS_N
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk_clk);
    check("busy_high", 32'(busy), 32'd1);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk_clk);
    check("busy_low", 32'(busy), 32'd0);

    // Register access vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rd) begin
        exp_q.push_back(vecs[i].data);
        read_burst($sformatf("vec%0d_rd%02h", i, vecs[i].addr), vecs[i].addr, 1, 1'b0, -1);
      end else begin
        write_reg(vecs[i].addr, vecs[i].data);
      end
    end

    // Sample capture with Measure on and interrupt enabled
    pulse_sample(16'h1234, 16'hFFFE, 16'h0100);
    repeat (4) @(negedge clk_clk);
    check("int_set", 32'(g_sensor_int), 32'd1);
    exp_q.push_back(8'h80);
    read_burst("int_source", 6'h30, 1, 1'b0, -1);
    check("int_kept", 32'(g_sensor_int), 32'd1);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    read_burst("burst", 6'h32, 6, 1'b1, -1);
    check("int_cleared", 32'(g_sensor_int), 32'd0);

    // New sample during a burst stays pending until CS_N rises
    nx = 16'hAAAA; ny = 16'h5555; nz = 16'h0F0F;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    read_burst("burst_coherent", 6'h32, 6, 1'b1, 0);
    check("int_set_wins", 32'(g_sensor_int), 32'd1);
    exp_q.push_back(8'h80);
    read_burst("ready_set_wins", 6'h30, 1, 1'b0, -1);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55); exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
    read_burst("burst_new", 6'h32, 6, 1'b1, -1);
    check("int_cleared2", 32'(g_sensor_int), 32'd0);

    // Address wrap 0x3F -> 0x00
    exp_q.push_back(8'h00); exp_q.push_back(8'hE5);
    read_burst("wrap", 6'h3F, 2, 1'b1, -1);

    // Write aborted after 4 data bits leaves INT_ENABLE untouched
    oe_bad   = 0;
    spi_cs_n = 1'b0;
    #(HALF);
    spi_bits(8'h2E, 8, 1'b0, rx);
    spi_bits(8'h00, 4, 1'b0, rx);
    spi_end();
    check("abort_oe", 32'(spi_sdat_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h80);
    read_burst("abort_inten", 6'h2E, 1, 1'b0, -1);

    // Measure off: sample pulses are dropped
    write_reg(6'h2D, 8'h00);
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    repeat (4) @(negedge clk_clk);
    check("drop_int", 32'(g_sensor_int), 32'd0);
    exp_q.push_back(8'h00);
    read_burst("drop_ready", 6'h30, 1, 1'b0, -1);
    exp_q.push_back(8'hAA);
    read_burst("drop_datax", 6'h32, 1, 1'b0, -1);

`ifdef GSENSOR_OFFSET_EN
    // Offset -1 applied to a zero sample wraps to 0xFFFF
    write_reg(6'h2D, 8'h08);
    write_reg(6'h1E, 8'hFF);
    pulse_sample(16'h0000, 16'h0000, 16'h0000);
    repeat (4) @(negedge clk_clk);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    read_burst("ofs_x", 6'h32, 2, 1'b1, -1);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
